// File: rtl/alu_cmd_driver.sv
`timescale 1ns/1ps
// alu_cmd_driver: command FIFO, 8x32 register file and a
// small FSM that sequences one ALU operation per command.
module alu_cmd_driver #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rs,
  input  logic [2:0]  cmd_rt,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_c,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [2:0]  res_rd,
  output logic        res_err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HOLD
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
  } cmd_t;

  state_t        state_q, state_d;
  cmd_t          fifo_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  cmd_t          ir_q, ir_d;
  logic [31:0]   rf_q [8];

  logic        res_valid_q, res_valid_d;
  logic        res_err_q, res_err_d;
  logic [31:0] res_data_q, res_data_d;
  logic [2:0]  res_rd_q, res_rd_d;

  logic        full, empty, push, pop;
  logic        wb_en, illegal;
  logic [31:0] wb_data;
  cmd_t        cmd_in;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign cmd_ready = !full && reset;
  assign push      = cmd_valid && cmd_ready;
  assign cmd_in    = '{op: cmd_op, rd: cmd_rd, rs: cmd_rs, rt: cmd_rt};

  assign illegal = ir_q.op[2] & ir_q.op[1];
  assign wb_data = illegal ? 32'd0 : alu_c;

  assign res_valid = res_valid_q;
  assign res_err   = res_err_q;
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;
  assign busy      = (state_q != IDLE) || !empty;

  // FIFO payload storage; pointers alone define what is live
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= cmd_in;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Register file: writeback is applied last so it beats a
  // same-cycle direct load to the same register; r0 is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      if (wr_en && wr_addr != 3'd0)
        rf_q[wr_addr] <= wr_data;
      if (wb_en && ir_q.rd != 3'd0)
        rf_q[ir_q.rd] <= wb_data;
    end
  end

  // State, instruction and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
    end
  end

  // Next state, FIFO pop, ALU drive and result capture
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    pop         = 1'b0;
    wb_en       = 1'b0;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          ir_d    = fifo_q[rptr_q];
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_a       = rf_q[ir_q.rs];
        alu_b       = rf_q[ir_q.rt];
        alu_op      = illegal ? 3'd0 : ir_q.op;
        wb_en       = 1'b1;
        res_data_d  = wb_data;
        res_rd_d    = ir_q.rd;
        res_err_d   = illegal;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            ir_d    = fifo_q[rptr_q];
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
`timescale 1ns/1ps
// tb_alu_cmd_driver: directed vectors against alu_cmd_driver
// with a behavioural ALU closing the loop.
module tb_alu_cmd_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op, cmd_rd, cmd_rs, cmd_rt;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_rd;
  logic        res_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] got_d [$];
  logic [2:0]  got_r [$];
  int          stamp [$];
  logic [31:0] exp_d [6];
  logic [2:0]  exp_r [6];
  logic [31:0] t1_exp [6];
  logic        f_pend;
  int          cyc;

  alu_cmd_driver #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_c     (alu_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_rd    (res_rd),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Six-operation ALU the block feeds
  always_comb begin
    alu_c = '0;
    case (alu_op)
      3'd0: alu_c = alu_a + alu_b;
      3'd1: alu_c = alu_a - alu_b;
      3'd2: alu_c = alu_a & alu_b;
      3'd3: alu_c = alu_a | alu_b;
      3'd4: alu_c = alu_a >> alu_b[4:0];
      3'd5: alu_c = $signed(alu_a) >>> alu_b[4:0];
      default: alu_c = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic push(input logic [2:0] op, input logic [2:0] rd,
                      input logic [2:0] rs, input logic [2:0] rt);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_rd = rd;
    cmd_rs = rs;
    cmd_rt = rt;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk("push_rdy", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (!res_valid && n < 50) begin
      step();
      n++;
    end
    chk("res_v", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic get_res(input string tag, input logic [31:0] d,
                         input logic [2:0] rd, input logic err);
    wait_res();
    chk(tag, res_data, d);
    chk({tag, "_rd"}, {29'd0, res_rd}, {29'd0, rd});
    chk({tag, "_err"}, {31'd0, res_err}, {31'd0, err});
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_rd = '0;
    cmd_rs = '0;
    cmd_rt = '0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    res_ready = 1'b0;

    // reset state
    step();
    step();
    chk("rst_rdy", {31'd0, cmd_ready}, 32'd0);
    chk("rst_val", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_alua", alu_a, 32'd0);
    reset = 1'b1;
    step();
    chk("rdy_up", {31'd0, cmd_ready}, 32'd1);

    // all six ops on r1/r2
    wr_reg(3'd1, 32'hFE00005D);
    wr_reg(3'd2, 32'h00000002);
    t1_exp = '{32'hFE00005F, 32'hFE00005B, 32'h00000000,
               32'hFE00005F, 32'h3F800017, 32'hFF800017};
    push(3'd0, 3'd3, 3'd1, 3'd2);
    chk("lat_n1", {31'd0, res_valid}, 32'd0);
    step();
    chk("exec_a", alu_a, 32'hFE00005D);
    chk("exec_b", alu_b, 32'h00000002);
    step();
    chk("lat_n2", {31'd0, res_valid}, 32'd1);
    get_res("op0", t1_exp[0], 3'd3, 1'b0);
    for (int i = 1; i < 6; i++) begin
      push(3'(i), 3'd3, 3'd1, 3'd2);
      get_res($sformatf("op%0d", i), t1_exp[i], 3'd3, 1'b0);
    end

    // fill FIFO while the result is stalled
    push(3'd0, 3'd4, 3'd1, 3'd2);
    push(3'd1, 3'd5, 3'd1, 3'd2);
    push(3'd3, 3'd6, 3'd1, 3'd2);
    push(3'd0, 3'd7, 3'd2, 3'd2);
    push(3'd4, 3'd3, 3'd1, 3'd2);
    chk("full_rdy", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1;
    cmd_op = 3'd1;
    cmd_rd = 3'd6;
    cmd_rs = 3'd2;
    cmd_rt = 3'd1;
    step();
    step();
    step();
    chk("full_hold", {31'd0, cmd_ready}, 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd1);
    exp_d = '{32'hFE00005F, 32'hFE00005B, 32'hFE00005F,
              32'h00000004, 32'h3F800017, 32'h01FFFFA5};
    exp_r = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd3, 3'd6};
    res_ready = 1'b1;
    cyc = 0;
    while (got_d.size() < 6 && cyc < 60) begin
      if (res_valid) begin
        got_d.push_back(res_data);
        got_r.push_back(res_rd);
        stamp.push_back(cyc);
      end
      f_pend = cmd_valid && cmd_ready;
      step();
      cyc++;
      if (f_pend) cmd_valid = 1'b0;
    end
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("drain_n", 32'(got_d.size()), 32'd6);
    for (int i = 0; i < got_d.size(); i++) begin
      chk($sformatf("drain%0d", i), got_d[i], exp_d[i]);
      chk($sformatf("drain%0d_rd", i), {29'd0, got_r[i]},
          {29'd0, exp_r[i]});
      if (i > 0)
        chk($sformatf("gap%0d", i), 32'(stamp[i] - stamp[i-1]), 32'd2);
    end

    // illegal op and r0 behaviour
    push(3'd7, 3'd4, 3'd1, 3'd2);
    get_res("ill", 32'd0, 3'd4, 1'b1);
    push(3'd3, 3'd5, 3'd4, 3'd0);
    get_res("r4_zero", 32'd0, 3'd5, 1'b0);
    push(3'd0, 3'd0, 3'd1, 3'd2);
    get_res("r0_wb", 32'hFE00005F, 3'd0, 1'b0);
    push(3'd3, 3'd5, 3'd0, 3'd0);
    get_res("r0_read", 32'd0, 3'd5, 1'b0);

    // writeback beats a same-cycle direct load
    wr_reg(3'd5, 32'd3);
    push(3'd0, 3'd3, 3'd5, 3'd2);
    step();
    wr_en = 1'b1;
    wr_addr = 3'd3;
    wr_data = 32'h12345678;
    step();
    wr_en = 1'b0;
    get_res("conf_wb", 32'd5, 3'd3, 1'b0);
    push(3'd3, 3'd7, 3'd3, 3'd0);
    get_res("conf_r3", 32'd5, 3'd7, 1'b0);

    // reset while holding a result with two queued
    push(3'd0, 3'd6, 3'd1, 3'd2);
    push(3'd0, 3'd6, 3'd1, 3'd2);
    push(3'd0, 3'd6, 3'd1, 3'd2);
    step();
    chk("pre_rst_v", {31'd0, res_valid}, 32'd1);
    reset = 1'b0;
    step();
    chk("mid_rst_v", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_b", {31'd0, busy}, 32'd0);
    chk("mid_rst_r", {31'd0, cmd_ready}, 32'd0);
    chk("mid_rst_d", res_data, 32'd0);
    reset = 1'b1;
    step();
    step();
    step();
    chk("post_rst_v", {31'd0, res_valid}, 32'd0);
    chk("post_rst_b", {31'd0, busy}, 32'd0);
    chk("post_rst_r", {31'd0, cmd_ready}, 32'd1);
    push(3'd3, 3'd2, 3'd1, 3'd3);
    get_res("rf_clear", 32'd0, 3'd2, 1'b0);

    // stable outputs while stalled
    wr_reg(3'd1, 32'hA5A5A5A5);
    push(3'd1, 3'd2, 3'd1, 3'd0);
    wait_res();
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold_d%0d", i), res_data, 32'hA5A5A5A5);
      chk($sformatf("hold_rd%0d", i), {29'd0, res_rd}, 32'd2);
      chk($sformatf("hold_op%0d", i), {29'd0, alu_op}, 32'd0);
    end
    get_res("hold_end", 32'hA5A5A5A5, 3'd2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
